// File: rtl/cache_tag_ctrl.sv
// Tag, valid and use-bit controller for a 16-set, 4-way cache lookup path.
// Misses refill through a request/response handshake; a full set asks an external policy for the victim.
module cache_tag_ctrl #(
    parameter int IDX_W  = 4,
    parameter int OFF_W  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic                            flush,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_hit,
    output logic [1:0]                      resp_way,
    output logic                            resp_evict,
    output logic [ADDR_W-IDX_W-OFF_W-1:0]   resp_evict_tag,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic                            mem_resp_valid,
    output logic                            pol_hit,
    output logic [3:0]                      pol_state,
    input  logic [3:0]                      pol_final_state,
    input  logic [31:0]                     pol_replace
);
    // state        | meaning
    // S_IDLE       | ready for a request; flush clears the arrays here
    // S_LOOKUP     | compare latched tag against the indexed set
    // S_POLICY     | set full on a miss: sample victim and use vector from the policy
    // S_REFILL_REQ | hold refill request until accepted
    // S_REFILL_WAIT| wait for refill completion, then write the victim way
    // S_RESP       | hold response until consumed
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_POLICY,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         victim_q, victim_d;
    logic [3:0]         pol_use_q, pol_use_d;
    logic               from_pol_q, from_pol_d;
    logic               resp_hit_q, resp_hit_d;
    logic [1:0]         resp_way_q, resp_way_d;
    logic               resp_evict_q, resp_evict_d;
    logic [TAG_W-1:0]   resp_etag_q, resp_etag_d;

    logic [3:0]         valid_q [SETS];
    logic [3:0]         use_q   [SETS];
    logic [TAG_W-1:0]   tags_q  [SETS][4];

    logic [3:0]         set_valid;
    logic [3:0]         set_use;
    logic [3:0]         hit_vec;
    logic [1:0]         hit_way;
    logic [1:0]         inv_way;
    logic               flush_clr;
    logic               use_we;
    logic [3:0]         use_wdata;
    logic               fill_we;
    logic               unused_bits;

    assign unused_bits = ^{pol_replace[31:2], req_addr[OFF_W-1:0]};

    // Setting the last clear bit would saturate the vector, so restart from the touched way.
    function automatic logic [3:0] bump_use(input logic [3:0] use_in, input logic [1:0] way);
        logic [3:0] onehot;
        logic [3:0] merged;
        onehot = 4'b0001 << way;
        merged = use_in | onehot;
        return (merged == 4'b1111) ? onehot : merged;
    endfunction

    assign set_valid = valid_q[idx_q];
    assign set_use   = use_q[idx_q];

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = set_valid[w] && (tags_q[idx_q][w] == tag_q);
        end
    end

    always_comb begin
        hit_way = 2'd0;
        inv_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (hit_vec[w])    hit_way = 2'(w);
            if (!set_valid[w]) inv_way = 2'(w);
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        victim_d     = victim_q;
        pol_use_d    = pol_use_q;
        from_pol_d   = from_pol_q;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        resp_evict_d = resp_evict_q;
        resp_etag_d  = resp_etag_q;
        flush_clr    = 1'b0;
        use_we       = 1'b0;
        use_wdata    = set_use;
        fill_we      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    flush_clr = 1'b1;
                end else if (req_valid) begin
                    tag_d   = req_addr[ADDR_W-1 -: TAG_W];
                    idx_d   = req_addr[OFF_W +: IDX_W];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (|hit_vec) begin
                    use_we       = 1'b1;
                    use_wdata    = bump_use(set_use, hit_way);
                    resp_hit_d   = 1'b1;
                    resp_way_d   = hit_way;
                    resp_evict_d = 1'b0;
                    resp_etag_d  = '0;
                    state_d      = S_RESP;
                end else if (!(&set_valid)) begin
                    victim_d   = inv_way;
                    from_pol_d = 1'b0;
                    state_d    = S_REFILL_REQ;
                end else begin
                    state_d = S_POLICY;
                end
            end
            S_POLICY: begin
                victim_d   = pol_replace[1:0];
                pol_use_d  = pol_final_state;
                from_pol_d = 1'b1;
                state_d    = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    fill_we      = 1'b1;
                    use_we       = 1'b1;
                    // A saturated policy vector would be presented back to the policy later.
                    if (from_pol_q)
                        use_wdata = (pol_use_q == 4'b1111) ? (4'b0001 << victim_q) : pol_use_q;
                    else
                        use_wdata = bump_use(set_use, victim_q);
                    resp_hit_d   = 1'b0;
                    resp_way_d   = victim_q;
                    resp_evict_d = set_valid[victim_q];
                    resp_etag_d  = set_valid[victim_q] ? tags_q[idx_q][victim_q] : '0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            idx_q        <= '0;
            victim_q     <= '0;
            pol_use_q    <= '0;
            from_pol_q   <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_evict_q <= 1'b0;
            resp_etag_q  <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            victim_q     <= victim_d;
            pol_use_q    <= pol_use_d;
            from_pol_q   <= from_pol_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            resp_evict_q <= resp_evict_d;
            resp_etag_q  <= resp_etag_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                use_q[s]   <= '0;
            end
        end else if (flush_clr) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                use_q[s]   <= '0;
            end
        end else begin
            if (use_we)  use_q[idx_q] <= use_wdata;
            if (fill_we) valid_q[idx_q][victim_q] <= 1'b1;
        end
    end

    // Tags are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (fill_we) tags_q[idx_q][victim_q] <= tag_q;
    end

    assign req_ready      = (state_q == S_IDLE) && !flush;
    assign resp_valid     = (state_q == S_RESP);
    assign resp_hit       = resp_hit_q;
    assign resp_way       = resp_way_q;
    assign resp_evict     = resp_evict_q;
    assign resp_evict_tag = resp_etag_q;
    assign mem_req_valid  = (state_q == S_REFILL_REQ);
    assign mem_addr       = mem_req_valid ? {tag_q, idx_q, {OFF_W{1'b0}}} : '0;
    assign pol_hit        = (state_q != S_POLICY);
    assign pol_state      = set_use;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: directed scenarios plus randomized traffic
// compared against a set/way array model of the cache.
module tb_cache_tag_ctrl;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 4;
    localparam int OFF_W  = 2;
    localparam int TAG_W  = 26;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              flush = 1'b0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              resp_hit;
    logic [1:0]        resp_way;
    logic              resp_evict;
    logic [TAG_W-1:0]  resp_evict_tag;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_resp_valid = 1'b0;
    logic              pol_hit;
    logic [3:0]        pol_state;
    logic [3:0]        pol_final_state = '0;
    logic [31:0]       pol_replace = '0;

    always #5 clk = ~clk;

    cache_tag_ctrl #(.IDX_W(IDX_W), .OFF_W(OFF_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_resp_valid(mem_resp_valid),
        .pol_hit(pol_hit), .pol_state(pol_state),
        .pol_final_state(pol_final_state), .pol_replace(pol_replace)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int bad_pst  = 0;

    // reference model
    logic             mvalid [16][4];
    logic [TAG_W-1:0] mtag   [16][4];
    logic [3:0]       muse   [16];

    logic             e_hit, e_evict, e_consult;
    logic [1:0]       e_way;
    logic [TAG_W-1:0] e_etag;
    logic [3:0]       e_pst;

    // observations of one transaction
    logic              o_timeout, o_hit, o_evict, o_saw_mem, o_unst_mem, o_unst_resp;
    logic [1:0]        o_way;
    logic [TAG_W-1:0]  o_etag;
    logic [ADDR_W-1:0] o_maddr;
    logic [3:0]        o_pol_st;
    int                o_pol_cnt, o_lat, o_mem_cnt, o_resp_cnt;

    always @(negedge clk) if (rst_n && pol_state === 4'hF) bad_pst++;

    task automatic model_clear();
        for (int s = 0; s < 16; s++) begin
            muse[s] = 4'h0;
            for (int w = 0; w < 4; w++) begin
                mvalid[s][w] = 1'b0;
                mtag[s][w]   = '0;
            end
        end
    endtask

    function automatic logic [3:0] mark_used(input logic [3:0] u, input int w);
        logic [3:0] r;
        r = u;
        r[w] = 1'b1;
        if (r == 4'hF) begin
            r = 4'h0;
            r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_access(input logic [ADDR_W-1:0] addr, input logic [1:0] rep,
                                input logic [3:0] fin);
        int idx, found, inv;
        logic [TAG_W-1:0] t;
        idx = int'(addr[5:2]);
        t = addr[31:6];
        e_pst = muse[idx];
        e_consult = 1'b0;
        e_evict = 1'b0;
        e_etag = '0;
        found = -1;
        inv = -1;
        for (int w = 3; w >= 0; w--) begin
            if (mvalid[idx][w] && mtag[idx][w] == t) found = w;
            if (!mvalid[idx][w]) inv = w;
        end
        if (found >= 0) begin
            e_hit = 1'b1;
            e_way = 2'(found);
            muse[idx] = mark_used(muse[idx], found);
        end else begin
            e_hit = 1'b0;
            if (inv >= 0) begin
                e_way = 2'(inv);
                muse[idx] = mark_used(muse[idx], inv);
            end else begin
                e_consult = 1'b1;
                e_way = rep;
                e_evict = 1'b1;
                e_etag = mtag[idx][rep];
                if (fin == 4'hF) begin
                    muse[idx] = 4'h0;
                    muse[idx][rep] = 1'b1;
                end else begin
                    muse[idx] = fin;
                end
            end
            mvalid[idx][e_way] = 1'b1;
            mtag[idx][e_way] = t;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input logic [ADDR_W-1:0] addr, input int mem_delay, input int resp_delay);
        int cyc, mem_wait, resp_wait, pulse_at, guard;
        logic done;
        o_timeout = 1'b0; o_saw_mem = 1'b0; o_unst_mem = 1'b0; o_unst_resp = 1'b0;
        o_pol_cnt = 0; o_pol_st = 4'h0; o_lat = -1; o_mem_cnt = 0; o_resp_cnt = 0;
        o_hit = 1'b0; o_way = 2'd0; o_evict = 1'b0; o_etag = '0; o_maddr = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = addr;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            o_timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; mem_wait = 0; resp_wait = 0; pulse_at = -1; done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_resp_valid = 1'b0;
            if (!pol_hit) begin
                o_pol_cnt++;
                o_pol_st = pol_state;
            end
            if (mem_req_valid) begin
                if (!o_saw_mem) begin
                    o_saw_mem = 1'b1;
                    o_maddr = mem_addr;
                end else if (mem_addr !== o_maddr) begin
                    o_unst_mem = 1'b1;
                end
                o_mem_cnt++;
                mem_req_ready = (mem_wait >= mem_delay);
                mem_wait++;
                if (mem_req_ready) pulse_at = cyc + 2;
            end else begin
                mem_req_ready = 1'b0;
            end
            if (cyc == pulse_at) mem_resp_valid = 1'b1;
            if (resp_valid) begin
                if (o_lat < 0) begin
                    o_lat = cyc;
                    o_hit = resp_hit; o_way = resp_way;
                    o_evict = resp_evict; o_etag = resp_evict_tag;
                end else if (resp_hit !== o_hit || resp_way !== o_way ||
                             resp_evict !== o_evict || resp_evict_tag !== o_etag) begin
                    o_unst_resp = 1'b1;
                end
                o_resp_cnt++;
                resp_ready = (resp_wait >= resp_delay);
                resp_wait++;
                if (resp_ready) done = 1'b1;
            end
        end
        if (!done) o_timeout = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_assert++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_assert++; if ({resp_hit, resp_way, resp_evict} !== 4'b0) begin n_fail++; $display("FAIL reset_resp_fields: got %b want 0000", {resp_hit, resp_way, resp_evict}); end
        n_assert++; if (resp_evict_tag !== '0) begin n_fail++; $display("FAIL reset_evict_tag: got %h want 0", resp_evict_tag); end
        n_assert++; if (mem_req_valid !== 1'b0 || mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem: got %b/%h want 0/0", mem_req_valid, mem_addr); end
        n_assert++; if (pol_hit !== 1'b1 || pol_state !== 4'h0) begin n_fail++; $display("FAIL reset_pol: got %b/%b want 1/0000", pol_hit, pol_state); end
    endtask

    task automatic test_cold_miss();
        run_txn(32'h0000_1000, 0, 0);
        n_assert++; if (o_timeout) begin n_fail++; $display("FAIL cold_timeout: got timeout want response"); end
        n_assert++; if (o_saw_mem !== 1'b1 || o_maddr !== 32'h0000_1000) begin n_fail++; $display("FAIL cold_mem: got %b/%h want 1/00001000", o_saw_mem, o_maddr); end
        n_assert++; if ({o_hit, o_way, o_evict} !== 4'b0000) begin n_fail++; $display("FAIL cold_resp: got hit=%b way=%0d evict=%b want 0/0/0", o_hit, o_way, o_evict); end
        n_assert++; if (o_pol_cnt != 0) begin n_fail++; $display("FAIL cold_policy: got %0d policy cycles want 0", o_pol_cnt); end
        model_access(32'h0000_1000, 2'd0, 4'h0);
    endtask

    task automatic test_hit_latency();
        model_access(32'h0000_1000, 2'd0, 4'h0);
        run_txn(32'h0000_1000, 0, 0);
        n_assert++; if (o_lat != 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", o_lat); end
        n_assert++; if (o_hit !== 1'b1 || o_way !== 2'd0 || o_evict !== 1'b0) begin n_fail++; $display("FAIL hit_resp: got hit=%b way=%0d evict=%b want 1/0/0", o_hit, o_way, o_evict); end
        n_assert++; if (o_saw_mem !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: got %b want 0", o_saw_mem); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_u [3];
        exp_u[0] = 4'b1001; exp_u[1] = 4'b1011; exp_u[2] = 4'b0100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn({26'h10 + 26'(i), 4'h0, 2'b00}, 0, 0);
            n_assert++; if (o_hit !== 1'b0 || o_way !== 2'(i)) begin n_fail++; $display("FAIL sat_fill%0d: got hit=%b way=%0d want 0/%0d", i, o_hit, o_way, i); end
        end
        n_assert++; if (pol_state !== 4'b1000) begin n_fail++; $display("FAIL sat_after_fill: got %b want 1000", pol_state); end
        for (int i = 0; i < 3; i++) begin
            run_txn({26'h10 + 26'(i), 4'h0, 2'b00}, 0, 0);
            n_assert++; if (o_hit !== 1'b1 || o_way !== 2'(i)) begin n_fail++; $display("FAIL sat_hit%0d: got hit=%b way=%0d want 1/%0d", i, o_hit, o_way, i); end
            n_assert++; if (pol_state !== exp_u[i]) begin n_fail++; $display("FAIL sat_use%0d: got %b want %b", i, pol_state, exp_u[i]); end
        end
    endtask

    task automatic test_policy_evict();
        run_txn({26'h10, 4'h0, 2'b00}, 0, 0);
        run_txn({26'h11, 4'h0, 2'b00}, 0, 0);
        n_assert++; if (pol_state !== 4'b0111) begin n_fail++; $display("FAIL evict_setup: got %b want 0111", pol_state); end
        pol_final_state = 4'b1000;
        pol_replace = 32'hABCD_1237;
        run_txn({26'h20, 4'h0, 2'b00}, 0, 0);
        n_assert++; if (o_pol_cnt != 1 || o_pol_st !== 4'b0111) begin n_fail++; $display("FAIL evict_policy: got cycles=%0d state=%b want 1/0111", o_pol_cnt, o_pol_st); end
        n_assert++; if (o_way !== 2'd3 || o_evict !== 1'b1 || o_etag !== 26'h13) begin n_fail++; $display("FAIL evict_resp: got way=%0d evict=%b tag=%h want 3/1/0000013", o_way, o_evict, o_etag); end
        n_assert++; if (pol_state !== 4'b1000) begin n_fail++; $display("FAIL evict_use: got %b want 1000", pol_state); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_txn(32'h0000_2088, 5, 3);
        n_assert++; if (o_mem_cnt != 6 || o_unst_mem) begin n_fail++; $display("FAIL bp_mem: got cycles=%0d unstable=%b want 6/0", o_mem_cnt, o_unst_mem); end
        n_assert++; if (o_maddr !== 32'h0000_2088) begin n_fail++; $display("FAIL bp_addr: got %h want 00002088", o_maddr); end
        n_assert++; if (o_resp_cnt != 4 || o_unst_resp) begin n_fail++; $display("FAIL bp_resp: got cycles=%0d unstable=%b want 4/0", o_resp_cnt, o_unst_resp); end
    endtask

    task automatic test_flush();
        run_txn(32'h0000_2088, 0, 0);
        n_assert++; if (o_hit !== 1'b1) begin n_fail++; $display("FAIL flush_prehit: got %b want 1", o_hit); end
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_2088;
        #1;
        n_assert++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        model_clear();
        run_txn(32'h0000_2088, 0, 0);
        n_assert++; if (o_hit !== 1'b0 || o_saw_mem !== 1'b1 || o_way !== 2'd0) begin n_fail++; $display("FAIL flush_miss: got hit=%b mem=%b way=%0d want 0/1/0", o_hit, o_saw_mem, o_way); end
    endtask

    task automatic test_reset_mid_refill();
        int guard;
        do_reset();
        run_txn(32'h0000_1000, 0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_2040;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!mem_req_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_assert++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_reach: got %b want 1", mem_req_valid); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_assert++; if (mem_req_valid !== 1'b0 || mem_addr !== '0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got mem=%b addr=%h resp=%b want 0/0/0", mem_req_valid, mem_addr, resp_valid); end
        n_assert++; if (pol_hit !== 1'b1 || pol_state !== 4'h0) begin n_fail++; $display("FAIL rmid_pol: got %b/%b want 1/0000", pol_hit, pol_state); end
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        run_txn(32'h0000_2040, 0, 0);
        n_assert++; if (o_hit !== 1'b0 || o_way !== 2'd0 || o_evict !== 1'b0) begin n_fail++; $display("FAIL rmid_fresh: got hit=%b way=%0d evict=%b want 0/0/0", o_hit, o_way, o_evict); end
        run_txn(32'h0000_1000, 0, 0);
        n_assert++; if (o_hit !== 1'b0 || o_way !== 2'd1) begin n_fail++; $display("FAIL rmid_second: got hit=%b way=%0d want 0/1", o_hit, o_way); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] addr;
        logic [1:0] rep;
        logic [3:0] fin;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 12) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                for (int s = 0; s < 16; s++) begin
                    muse[s] = 4'h0;
                    for (int w = 0; w < 4; w++) mvalid[s][w] = 1'b0;
                end
            end
            addr = {26'h100 + 26'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            rep = 2'($urandom_range(0, 3));
            fin = 4'($urandom_range(0, 14));
            pol_replace = ($urandom() & 32'hFFFF_FFFC) | {30'b0, rep};
            pol_final_state = fin;
            model_access(addr, rep, fin);
            run_txn(addr, $urandom_range(0, 2), $urandom_range(0, 2));
            n_assert++; if (o_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout: got timeout want response", i); end
            n_assert++; if (o_hit !== e_hit || o_way !== e_way) begin n_fail++; $display("FAIL rnd%0d_hitway: got %b/%0d want %b/%0d", i, o_hit, o_way, e_hit, e_way); end
            n_assert++; if (o_evict !== e_evict || (e_evict && o_etag !== e_etag)) begin n_fail++; $display("FAIL rnd%0d_evict: got %b/%h want %b/%h", i, o_evict, o_etag, e_evict, e_etag); end
            n_assert++; if (o_saw_mem !== !e_hit || (!e_hit && o_maddr !== {addr[31:2], 2'b00})) begin n_fail++; $display("FAIL rnd%0d_mem: got %b/%h want %b/%h", i, o_saw_mem, o_maddr, !e_hit, {addr[31:2], 2'b00}); end
            n_assert++; if (o_pol_cnt != (e_consult ? 1 : 0) || (e_consult && o_pol_st !== e_pst)) begin n_fail++; $display("FAIL rnd%0d_policy: got %0d/%b want %0d/%b", i, o_pol_cnt, o_pol_st, e_consult ? 1 : 0, e_pst); end
            if (e_hit) begin
                n_assert++; if (o_lat != 2) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 2", i, o_lat); end
            end
            n_assert++; if (pol_state !== muse[addr[5:2]]) begin n_fail++; $display("FAIL rnd%0d_use: got %b want %b", i, pol_state, muse[addr[5:2]]); end
        end
    endtask

    task automatic test_never_full();
        n_assert++; if (bad_pst != 0) begin n_fail++; $display("FAIL pol_state_full: got %0d cycles with 1111 want 0", bad_pst); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_cold_miss();
        test_hit_latency();
        test_saturation();
        test_policy_evict();
        test_backpressure();
        test_flush();
        test_reset_mid_refill();
        test_random();
        test_never_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
